// File: rtl/addsub_alu_pipe.sv
// Registered add/subtract ALU with a stored carry flag and a one-deep valid/ready output stage.
// Build option: define ADDSUB_ALU_SAT_EN to clamp overflowing results to the signed max/min.
module addsub_alu_pipe #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             carry,
  output logic             zero,
  output logic             overflow,
  output logic             negative,
  input  logic             clr_c
);

  localparam int MSB = WIDTH - 1;

  // Handshake: a bundle moves when valid and ready are both high at a rising
  // edge; valid never depends on ready, and the result slot frees itself in the
  // same cycle it is consumed, so ready = slot empty or being drained.
  logic             xfer;
  logic             c_flag;
  logic             sub;
  logic             cin;
  logic [WIDTH-1:0] b_eff;
  logic [WIDTH:0]   full;
  logic [WIDTH-1:0] sum;
  logic             ovf;
  logic [WIDTH-1:0] res_next;

  assign in_ready = !out_valid || out_ready;
  assign xfer     = in_valid && in_ready;

  always_comb begin
    sub   = op[0];
    b_eff = b ^ {WIDTH{sub}};
    // A clear coinciding with a transfer wins: the adder sees C = 0.
    cin   = op[1] ? (c_flag & ~clr_c) : sub;
    full  = {1'b0, a} + {1'b0, b_eff} + {{WIDTH{1'b0}}, cin};
    sum   = full[MSB:0];
    ovf   = (a[MSB] == b_eff[MSB]) && (sum[MSB] != a[MSB]);
    res_next = sum;
`ifdef ADDSUB_ALU_SAT_EN
    // On overflow the true result has the sign shared by both operands.
    if (ovf) begin
      res_next = a[MSB] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
    end
`endif
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      result    <= '0;
      carry     <= 1'b0;
      zero      <= 1'b0;
      overflow  <= 1'b0;
      negative  <= 1'b0;
      c_flag    <= 1'b0;
    end else begin
      if (xfer) begin
        out_valid <= 1'b1;
        result    <= res_next;
        carry     <= full[WIDTH];
        zero      <= ~|res_next;
        overflow  <= ovf;
        negative  <= res_next[MSB];
        c_flag    <= full[WIDTH];
      end else begin
        if (out_ready) begin
          out_valid <= 1'b0;
        end
        if (clr_c) begin
          c_flag <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_addsub_alu_pipe.sv
// Bench for addsub_alu_pipe at WIDTH=4: directed literal cases, exhaustive sweep and
// random traffic checked against a signed/unsigned arithmetic model and an expected queue.
module tb_addsub_alu_pipe;

  localparam int W = 4;

  logic         clk;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [1:0]   op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] result;
  logic         carry;
  logic         zero;
  logic         overflow;
  logic         negative;
  logic         clr_c;

  int n_tests = 0;
  int n_fail  = 0;

  addsub_alu_pipe #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .op       (op),
    .a        (a),
    .b        (b),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .result   (result),
    .carry    (carry),
    .zero     (zero),
    .overflow (overflow),
    .negative (negative),
    .clr_c    (clr_c)
  );

  // ---------------- clock / reset ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Packed expectation: {result[3:0], carry, zero, overflow, negative}
  logic [7:0] exp_q[$];
  logic       m_ov;
  logic [3:0] m_res;
  logic       m_c, m_z, m_v, m_n;
  logic       m_cflag;

  function automatic logic [7:0] model_calc(input logic [1:0] o, input logic [3:0] x,
                                            input logic [3:0] y, input logic c_in);
    int sx, sy, ts, u, cin;
    logic [3:0] r;
    logic c, v;
    sx  = (x > 7) ? int'(x) - 16 : int'(x);
    sy  = (y > 7) ? int'(y) - 16 : int'(y);
    cin = o[1] ? int'(c_in) : int'(o[0]);
    if (!o[0]) begin
      ts = sx + sy + cin;
      u  = int'(x) + int'(y) + cin;
      c  = (u >= 16);
    end else begin
      ts = sx - sy - (1 - cin);
      u  = int'(x) - int'(y) - (1 - cin);
      c  = (u >= 0);
    end
    v = (ts > 7) || (ts < -8);
    r = ts[3:0];
`ifdef ADDSUB_ALU_SAT_EN
    if (v) r = (ts > 7) ? 4'h7 : 4'h8;
`endif
    return {r, c, (r == 4'h0), v, r[3]};
  endfunction

  always @(posedge clk or negedge rst_n) begin
    logic [7:0] pk;
    if (!rst_n) begin
      m_ov = 1'b0; m_res = '0; m_c = 1'b0; m_z = 1'b0; m_v = 1'b0; m_n = 1'b0;
      m_cflag = 1'b0;
      exp_q.delete();
    end else if (in_valid && (!m_ov || out_ready)) begin
      pk = model_calc(op, a, b, m_cflag && !clr_c);
      {m_res, m_c, m_z, m_v, m_n} = pk;
      m_cflag = pk[3];
      m_ov = 1'b1;
      exp_q.push_back(pk);
    end else begin
      if (out_ready) m_ov = 1'b0;
      if (clr_c) m_cflag = 1'b0;
    end
  end

  // ---------------- scoreboard / compare ----------------
  always @(negedge clk) begin
    logic [7:0] e;
    if (!rst_n) begin
      check("rst_out_valid", out_valid, 0);
      check("rst_in_ready", in_ready, 1);
      check("rst_outputs", {result, carry, zero, overflow, negative}, 0);
    end else begin
      check("out_valid", out_valid, m_ov);
      check("in_ready", in_ready, !m_ov || out_ready);
      if (m_ov) check("held_outputs", {result, carry, zero, overflow, negative},
                      {m_res, m_c, m_z, m_v, m_n});
      if (out_valid && out_ready) begin
        if (exp_q.size() == 0) begin
          check("consume_unexpected", 1, 0);
        end else begin
          e = exp_q.pop_front();
          check("consumed_result", {result, carry, zero, overflow, negative}, e);
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic step(input logic v, input logic [1:0] o, input logic [3:0] x,
                      input logic [3:0] y, input logic ordy, input logic clr);
    in_valid = v; op = o; a = x; b = y; out_ready = ordy; clr_c = clr;
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [1:0] o, input logic [3:0] x, input logic [3:0] y,
                      input logic clr);
    logic acc;
    int guard;
    guard = 0;
    in_valid = 1'b1; op = o; a = x; b = y; clr_c = clr;
    do begin
      out_ready = ($urandom_range(0, 9) < 7);
      @(negedge clk);
      acc = in_ready;
      @(posedge clk);
      #1;
      clr_c = 1'b0;
      guard++;
    end while (!acc && guard < 100);
    if (!acc) check("send_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic check_out(input string name, input logic [3:0] r, input logic c,
                           input logic z, input logic v, input logic n);
    check(name, {result, carry, zero, overflow, negative}, {r, c, z, v, n});
    check({name, "_model"}, {m_res, m_c, m_z, m_v, m_n}, {r, c, z, v, n});
  endtask

  // ---------------- main sequence ----------------
  initial begin
    rst_n = 1'b0; in_valid = 1'b0; op = '0; a = '0; b = '0; out_ready = 1'b0; clr_c = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_result", result, 0);
    check("reset_valid", out_valid, 0);
    rst_n = 1'b1;

    // ADD 7+1: signed overflow
    step(1, 2'b00, 4'h7, 4'h1, 1, 0);
`ifdef ADDSUB_ALU_SAT_EN
    check_out("add_7_1", 4'h7, 0, 0, 1, 0);
`else
    check_out("add_7_1", 4'h8, 0, 0, 1, 1);
`endif
    step(1, 2'b01, 4'h3, 4'h3, 1, 0);
    check_out("sub_3_3", 4'h0, 1, 1, 0, 0);
    step(1, 2'b01, 4'h0, 4'h1, 1, 0);
    check_out("sub_0_1", 4'hF, 0, 0, 0, 1);
    step(1, 2'b00, 4'hF, 4'h1, 1, 0);
    check_out("add_f_1", 4'h0, 1, 1, 0, 0);
    step(1, 2'b10, 4'h0, 4'h0, 1, 0);
    check_out("adc_0_0", 4'h1, 0, 0, 0, 0);

    // clr_c coinciding with ADC: the transfer must see C = 0
    step(1, 2'b00, 4'hF, 4'h1, 1, 0);
    step(1, 2'b10, 4'h0, 4'h0, 1, 1);
    check_out("adc_clr", 4'h0, 0, 1, 0, 0);
    step(1, 2'b11, 4'h5, 4'h2, 1, 0);
    check_out("sbc_5_2_c0", 4'h2, 1, 0, 0, 0);

    // Stall with out_ready=0: result held, in_ready low
    step(1, 2'b00, 4'hE, 4'h3, 1, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, 2'b00, 4'h9, 4'h9, 0, 0);
      check("stall_in_ready", in_ready, 0);
      check("stall_result", result, 4'h1);
    end

    // Reset while a result is pending (C was set by E+3)
    rst_n = 1'b0;
    #1;
    check("midrst_out_valid", out_valid, 0);
    check("midrst_result", result, 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step(1, 2'b10, 4'h0, 4'h0, 1, 0);
    check("post_rst_valid", out_valid, 1);
    check_out("post_rst_adc", 4'h0, 0, 1, 0, 0);
    step(0, 2'b00, 4'h0, 4'h0, 1, 0);

    // Exhaustive sweep, random out_ready
    for (int o = 0; o < 4; o++)
      for (int x = 0; x < 16; x++)
        for (int y = 0; y < 16; y++)
          send(o[1:0], x[3:0], y[3:0], 1'b0);

    // Random traffic with clears and idle gaps
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0)
        step(0, 2'($urandom), 4'($urandom), 4'($urandom), 1'($urandom),
             ($urandom_range(0, 3) == 0));
      send(2'($urandom), 4'($urandom), 4'($urandom), ($urandom_range(0, 7) == 0));
    end

    // Drain and confirm nothing left unconsumed
    repeat (3) step(0, 2'b00, 4'h0, 4'h0, 1, 0);
    check("drain_out_valid", out_valid, 0);
    check("exp_q_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
